// File: rtl/fibonacci_checker.sv
// Streaming checker: compares incoming terms (one or two per transfer) against
// the Fibonacci sequence 1,1,2,3,... modulo 2^W and records the first mismatch.
module fibonacci_checker #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         restart,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  input  logic         in_pair,
  output logic         checking,
  output logic         err,
  output logic [W-1:0] err_index,
  output logic [W-1:0] term_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_exp_a;
  logic [W-1:0] r_exp_b;
  logic [W-1:0] r_term_cnt;
  logic [W-1:0] r_err_index;
  logic         r_err;
  logic         r_checking;

  logic         w_xfer;
  logic         w_mis_a;
  logic         w_mis_b;
  logic         w_mis;
  logic [W-1:0] w_sum_ab;
  logic [W-1:0] w_sum_abb;
  logic [W:0]   w_step;
  logic [W:0]   w_cnt_wide;
  logic [W-1:0] w_cnt_sat;
  logic [W-1:0] w_cnt_p1;

  assign in_ready = (r_state != S_IDLE);

  // restart discards any transfer offered in the same cycle
  assign w_xfer    = in_valid & in_ready & ~restart;
  assign w_mis_a   = (in_num != r_exp_a);
  assign w_mis_b   = in_pair & (in_num2 != r_exp_b);
  assign w_mis     = w_mis_a | w_mis_b;
  assign w_sum_ab  = r_exp_a + r_exp_b;
  assign w_sum_abb = w_sum_ab + r_exp_b;

  assign w_step     = in_pair ? (W+1)'(2) : (W+1)'(1);
  assign w_cnt_wide = {1'b0, r_term_cnt} + w_step;
  assign w_cnt_sat  = w_cnt_wide[W] ? '1 : w_cnt_wide[W-1:0];
  assign w_cnt_p1   = r_term_cnt + W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CHECK;
      S_CHECK: if (w_xfer && w_mis) w_state_nxt = S_ERROR;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
    if (restart) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exp_a     <= W'(1);
      r_exp_b     <= W'(1);
      r_term_cnt  <= '0;
      r_err       <= 1'b0;
      r_err_index <= '0;
      r_checking  <= 1'b0;
    end else begin
      r_checking <= (w_state_nxt == S_CHECK);
      if (restart) begin
        r_exp_a     <= W'(1);
        r_exp_b     <= W'(1);
        r_term_cnt  <= '0;
        r_err       <= 1'b0;
        r_err_index <= '0;
      end else if (w_xfer) begin
        if (in_pair) begin
          r_exp_a <= w_sum_ab;
          r_exp_b <= w_sum_abb;
        end else begin
          r_exp_a <= r_exp_b;
          r_exp_b <= w_sum_ab;
        end
        r_term_cnt <= w_cnt_sat;
        // only the first mismatch is recorded; ERROR keeps the flag frozen
        if ((r_state == S_CHECK) && w_mis) begin
          r_err       <= 1'b1;
          r_err_index <= w_mis_a ? r_term_cnt : w_cnt_p1;
        end
      end
    end
  end

  assign checking  = r_checking;
  assign err       = r_err;
  assign err_index = r_err_index;
  assign term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench for fibonacci_checker: expected post-transfer state is queued
// by the stimulus and compared by an independent monitor after each transfer.
module tb_fibonacci_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_num;
  logic [15:0] in_num2;
  logic        in_pair;
  logic        checking;
  logic        err;
  logic [15:0] err_index;
  logic [15:0] term_cnt;

  typedef struct packed {
    logic        e;
    logic [15:0] idx;
    logic [15:0] cnt;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  fibonacci_checker #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_num2   (in_num2),
    .in_pair   (in_pair),
    .checking  (checking),
    .err       (err),
    .err_index (err_index),
    .term_cnt  (term_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: at each negedge, settle the transfer sampled at the previous
  // negedge (which completed on the posedge in between), then sample the next.
  initial begin
    logic pend;
    exp_t x;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          x = sb.pop_front();
          check("sb_err",       {31'd0, err},       {31'd0, x.e});
          check("sb_err_index", {16'd0, err_index}, {16'd0, x.idx});
          check("sb_term_cnt",  {16'd0, term_cnt},  {16'd0, x.cnt});
          check("sb_checking",  {31'd0, checking},  {31'd0, x.chk});
        end
      end
      pend = in_valid && in_ready && !restart && rst;
    end
  end

  task automatic single(input logic [15:0] v, input logic e, input logic [15:0] idx,
                        input logic [15:0] cnt, input logic chk);
    in_valid = 1'b1; in_pair = 1'b0; in_num = v; in_num2 = '0;
    sb.push_back('{e: e, idx: idx, cnt: cnt, chk: chk});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pair(input logic [15:0] v1, input logic [15:0] v2, input logic e,
                      input logic [15:0] idx, input logic [15:0] cnt, input logic chk);
    in_valid = 1'b1; in_pair = 1'b1; in_num = v1; in_num2 = v2;
    sb.push_back('{e: e, idx: idx, cnt: cnt, chk: chk});
    @(posedge clk); #1;
    in_valid = 1'b0; in_pair = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_restart(input string name, input logic with_data);
    restart = 1'b1;
    in_valid = with_data; in_num = 16'd7; in_num2 = 16'd9; in_pair = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0; in_pair = 1'b0;
    check({name, "_cnt"},   {16'd0, term_cnt},  0);
    check({name, "_err"},   {31'd0, err},       0);
    check({name, "_idx"},   {16'd0, err_index}, 0);
    check({name, "_ready"}, {31'd0, in_ready},  0);
    check({name, "_chk"},   {31'd0, checking},  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a, b, t;
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; restart = 1'b0;
    in_valid = 1'b0; in_num = '0; in_num2 = '0; in_pair = 1'b0;
    #2;
    check("rst_cnt",   {16'd0, term_cnt}, 0);
    check("rst_err",   {31'd0, err},      0);
    check("rst_ready", {31'd0, in_ready}, 0);
    check("rst_chk",   {31'd0, checking}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, in_ready}, 0);

    pulse_start();
    check("start_chk",   {31'd0, checking}, 1);
    check("start_ready", {31'd0, in_ready}, 1);
    single(16'd1, 0, 0, 1, 1);
    single(16'd1, 0, 0, 2, 1);
    single(16'd2, 0, 0, 3, 1);
    single(16'd3, 0, 0, 4, 1);
    single(16'd5, 0, 0, 5, 1);
    single(16'd8, 0, 0, 6, 1);
    drain("singles");

    do_restart("restart_a", 1'b0);
    pulse_start();
    pair(16'd1,  16'd1,  0, 0, 2, 1);
    pair(16'd2,  16'd3,  0, 0, 4, 1);
    pair(16'd5,  16'd8,  0, 0, 6, 1);
    pair(16'd13, 16'd21, 0, 0, 8, 1);
    drain("pairs");
    do_restart("restart_mid", 1'b1);

    pulse_start();
    single(16'd1, 0, 0, 1, 1);
    single(16'd1, 0, 0, 2, 1);
    single(16'd2, 0, 0, 3, 1);
    single(16'd4, 1, 3, 4, 0);
    single(16'd5, 1, 3, 5, 0);
    drain("err_single");
    check("err_ready", {31'd0, in_ready}, 1);
    pulse_start();
    check("err_start_chk", {31'd0, checking}, 0);
    check("err_start_err", {31'd0, err},      1);
    check("err_hold_cnt",  {16'd0, term_cnt}, 5);

    do_restart("restart_b", 1'b0);
    pulse_start();
    pair(16'd1, 16'd1, 0, 0, 2, 1);
    pair(16'd2, 16'd4, 1, 3, 4, 0);
    drain("err_pair_b");
    do_restart("restart_c", 1'b0);
    pulse_start();
    pair(16'd1, 16'd1, 0, 0, 2, 1);
    pair(16'd9, 16'd3, 1, 2, 4, 0);
    pair(16'd5, 16'd8, 1, 2, 6, 0);
    drain("err_pair_a");

    do_restart("restart_d", 1'b0);
    pulse_start();
    a = 16'd1; b = 16'd1;
    for (int k = 0; k < 25; k++) begin
      if (k == 11)      pair(16'd28657, 16'd46368, 0, 0, 16'(2*k+2), 1);
      else if (k == 12) pair(16'd9489,  16'd55857, 0, 0, 16'(2*k+2), 1);
      else              pair(a, b, 0, 0, 16'(2*k+2), 1);
      t = a + b;
      b = t + b;
      a = t;
    end
    drain("wrap");

    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_cnt",   {16'd0, term_cnt}, 0);
    check("async_err",   {31'd0, err},      0);
    check("async_ready", {31'd0, in_ready}, 0);
    check("async_chk",   {31'd0, checking}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_chk", {31'd0, checking}, 0);
    pulse_start();
    single(16'd1, 0, 0, 1, 1);
    single(16'd2, 1, 1, 2, 0);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 Parameter: W, default 16, data width of each term and of all counters/indices.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 start  input  1  one-cycle pulse; begins checking from IDLE.
REQ-005 restart  input  1  synchronous clear back to IDLE from any state.
REQ-006 in_valid  input  1  producer offers data this cycle.
REQ-007 in_ready  output  1  checker can accept data this cycle.
REQ-008 in_num  input  W  earlier (or only) term offered.
REQ-009 in_num2  input  W  later term; meaningful only when in_pair=1.
REQ-010 in_pair  input  1  1: two terms offered (in_num then in_num2); 0: one term (in_num).
REQ-011 checking  output  1  1 while in CHECK state.
REQ-012 err  output  1  sticky mismatch flag.
REQ-013 err_index  output  W  0-based index of first mismatching term.
REQ-014 term_cnt  output  W  number of terms accepted since last start.

Function
REQ-015 Reference sequence SHALL be 1, 1, 2, 3, 5, 8, ... with every sum taken modulo 2^W (wrap, no saturation, no error on wrap).
REQ-016 Internal state: exp_a (next expected term), exp_b (term after), states IDLE, CHECK, ERROR.
REQ-017 Transfer occurs in a cycle iff in_valid=1 and in_ready=1; no other cycle changes exp_a, exp_b, term_cnt.
REQ-018 in_ready SHALL be 0 in IDLE, 1 in CHECK and ERROR (ERROR drains the stream without stalling the producer).
REQ-019 IDLE: exp_a=1, exp_b=1, term_cnt=0, err=0, err_index=0; start=1 -> CHECK next cycle.
REQ-020 CHECK, single transfer: mismatch iff in_num != exp_a; then exp_a<=exp_b, exp_b<=exp_a+exp_b.
REQ-021 CHECK, pair transfer: mismatch iff in_num != exp_a or in_num2 != exp_b; then exp_a<=exp_a+exp_b, exp_b<=exp_a+2*exp_b (mod 2^W).
REQ-022 term_cnt SHALL increase by 1 (single) or 2 (pair) per transfer, saturating at 2^W-1.
REQ-023 On first mismatch: err<=1, err_index<=term_cnt if in_num mismatched, else term_cnt+1; state -> ERROR next cycle, same-cycle latency 1 for err.
REQ-024 ERROR: transfers accepted and counted per REQ-022; exp_a/exp_b keep advancing; err and err_index frozen until restart or reset.
REQ-025 restart has priority over start and over any same-cycle transfer: next state IDLE with REQ-019 values, transfer discarded.
REQ-026 start in CHECK or ERROR SHALL be ignored.
REQ-027 checking SHALL be a registered decode of state (1 only in CHECK).

Reset
REQ-028 rst=0 SHALL immediately (without clock) force IDLE, exp_a=1, exp_b=1, term_cnt=0, err=0, err_index=0, in_ready=0, checking=0.
REQ-029 Reset deassertion SHALL take effect at the following posedge clk; rst asserted mid-stream discards in-flight state.

Verification
REQ-030 Reset, start, single transfers 1,1,2,3,5,8 -> err=0, term_cnt=6, checking=1.
REQ-031 Reset, start, pair transfers (1,1),(2,3),(5,8),(13,21) -> err=0, term_cnt=8.
REQ-032 Reset, start, singles 1,1,2,4,5 -> err=1 one cycle after term 4, err_index=3, state ERROR, term_cnt=5, in_ready=1.
REQ-033 Pair (1,1) then pair (2,4) -> err_index=3; pair (1,1) then (9,3) -> err_index=2.
REQ-034 W=16, run 25 pair transfers -> terms 24, 25 compare against 46368 and 75025 mod 65536=9489, err=0.
REQ-035 Mid-stream restart with in_valid=1 -> next cycle IDLE, term_cnt=0, err=0, in_ready=0; async rst=0 between clocks -> outputs clear before next edge.
